// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Used by pc_sequencer, pc_return_stack and the branch selection mux.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int PC_WIDTH = 17;

  localparam logic [PC_WIDTH-1:0] VEC_22 = 17'd22;
  localparam logic [PC_WIDTH-1:0] VEC_12 = 17'd12;

  localparam int unsigned DEF_RESET_VECTOR = 0;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address stack: register array plus depth pointer.
// push+pop together replaces the top entry in place.
module pc_return_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(DEPTH));
  assign top_idx = AW'(depth_q - DW'(1));
  assign wr_idx  = depth_q[AW-1:0];
  assign depth   = depth_q;
  assign top     = empty ? '0 : mem[top_idx];

  // Stack update; misuse is filtered here as well as upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && pop) begin
      if (!empty) begin
        mem[top_idx] <= din;
      end
    end else if (push) begin
      if (!full) begin
        mem[wr_idx] <= din;
        depth_q     <= depth_q + DW'(1);
      end
    end else if (pop) begin
      if (!empty) begin
        depth_q <= depth_q - DW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register stage behind the branch selection mux, with return stack.
// Optional return stack and fault detection: define PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          WIDTH        = PC_WIDTH,
  parameter int          DEPTH        = 8,
  parameter int unsigned RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [WIDTH-1:0]       NextPc,
  input  logic                   Stall,
  input  logic                   Call,
  input  logic                   Ret,
  output logic [WIDTH-1:0]       Pc,
  output logic [WIDTH-1:0]       PcPlus1,
  output logic [WIDTH-1:0]       RetAddr,
  output logic                   InstrValid,
  output logic                   Fault,
  output logic [$clog2(DEPTH):0] StackDepth
);

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic [WIDTH-1:0] pc_q;
  logic             run_go;
  logic             misuse;

  assign run_go  = (state_q == RUN) && !Stall;
  assign Pc      = pc_q;
  assign PcPlus1 = pc_q + WIDTH'(1);

`ifdef PC_SEQ_RAS_EN
  logic stk_full;
  logic stk_empty;

  assign misuse = (Call && !Ret && stk_full)
                || (Ret && stk_empty);

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (Clock),
    .rst_n (Reset_n),
    .push  (Call && run_go && !misuse),
    .pop   (Ret && run_go && !misuse),
    .din   (PcPlus1),
    .top   (RetAddr),
    .depth (StackDepth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign Fault = (state_q == FAULT);
`else
  logic unused_ras;

  assign unused_ras = Call ^ Ret;
  assign misuse     = 1'b0;
  assign RetAddr    = '0;
  assign StackDepth = '0;
  assign Fault      = 1'b0;
`endif

  assign InstrValid = (state_q == RUN);

  // State register and PC capture.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BOOT;
      pc_q    <= WIDTH'(RESET_VECTOR);
    end else begin
      state_q <= state_d;
      if (run_go) begin
        pc_q <= NextPc;
      end
    end
  end

  // Next state: one boot cycle, then run until a stack misuse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!Stall && misuse) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Stack scenarios are exercised when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

  logic        Clock;
  logic        Reset_n;
  logic [16:0] NextPc;
  logic        Stall;
  logic        Call;
  logic        Ret;
  logic [16:0] Pc;
  logic [16:0] PcPlus1;
  logic [16:0] RetAddr;
  logic        InstrValid;
  logic        Fault;
  logic [3:0]  StackDepth;

  int checks;
  int errors;

  pc_sequencer #(
    .WIDTH        (17),
    .DEPTH        (8),
    .RESET_VECTOR (0)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .NextPc     (NextPc),
    .Stall      (Stall),
    .Call       (Call),
    .Ret        (Ret),
    .Pc         (Pc),
    .PcPlus1    (PcPlus1),
    .RetAddr    (RetAddr),
    .InstrValid (InstrValid),
    .Fault      (Fault),
    .StackDepth (StackDepth)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Call = 0;
    Ret = 0;
    Stall = 0;
    #2;
    Reset_n = 0;
    #3;
    Reset_n = 1;
  endtask

  // reset, then one edge to leave BOOT; Pc still 0
  task automatic boot();
    do_reset();
    NextPc = 17'h0;
    step();
  endtask

  task automatic test_reset();
    Reset_n = 1;
    NextPc = 17'h1234;
    Stall = 0;
    Call = 0;
    Ret = 0;
    step();
    Reset_n = 0;
    #2;
    checks++;
    if (Pc !== 17'h0) begin
      errors++;
      $display("FAIL reset_pc got %h want 0", Pc);
    end
    checks++;
    if (InstrValid !== 1'b0 || Fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got iv=%b f=%b want 0 0",
               InstrValid, Fault);
    end
    checks++;
    if (StackDepth !== 4'd0 || RetAddr !== 17'h0) begin
      errors++;
      $display("FAIL reset_stack got d=%0d ra=%h want 0 0",
               StackDepth, RetAddr);
    end
  endtask

  task automatic test_boot();
    do_reset();
    NextPc = 17'h00010;
    Stall = 1;
    #1;
    checks++;
    if (Pc !== 17'h0 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle got pc=%h iv=%b want 0 0",
               Pc, InstrValid);
    end
    step();
    Stall = 0;
    checks++;
    if (Pc !== 17'h0 || InstrValid !== 1'b1) begin
      errors++;
      $display("FAIL boot_exit got pc=%h iv=%b want 0 1",
               Pc, InstrValid);
    end
    step();
    checks++;
    if (Pc !== 17'h00010 || InstrValid !== 1'b1) begin
      errors++;
      $display("FAIL run_first got pc=%h iv=%b want 10 1",
               Pc, InstrValid);
    end
    NextPc = 17'h00abc;
    step();
    checks++;
    if (Pc !== 17'h00abc) begin
      errors++;
      $display("FAIL run_second got pc=%h want abc", Pc);
    end
  endtask

  task automatic test_wrap();
    boot();
    NextPc = 17'h1FFFF;
    step();
    checks++;
    if (Pc !== 17'h1FFFF || PcPlus1 !== 17'h0) begin
      errors++;
      $display("FAIL wrap got pc=%h p1=%h want 1ffff 0",
               Pc, PcPlus1);
    end
    NextPc = 17'h0ffff;
    step();
    checks++;
    if (PcPlus1 !== 17'h10000) begin
      errors++;
      $display("FAIL plus1 got %h want 10000", PcPlus1);
    end
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_call_ret();
    boot();
    NextPc = 17'h00100;
    step();
    Call = 1;
    NextPc = 17'h00200;
    step();
    checks++;
    if (RetAddr !== 17'h00101 || StackDepth !== 4'd1) begin
      errors++;
      $display("FAIL call got ra=%h d=%0d want 101 1",
               RetAddr, StackDepth);
    end
    checks++;
    if (Pc !== 17'h00200) begin
      errors++;
      $display("FAIL call_pc got %h want 200", Pc);
    end
    Call = 0;
    Ret = 1;
    NextPc = 17'h00101;
    step();
    Ret = 0;
    checks++;
    if (RetAddr !== 17'h0 || StackDepth !== 4'd0
        || Fault !== 1'b0) begin
      errors++;
      $display("FAIL ret got ra=%h d=%0d f=%b want 0 0 0",
               RetAddr, StackDepth, Fault);
    end
  endtask

  task automatic test_overflow();
    boot();
    Call = 1;
    for (int k = 0; k < 8; k++) begin
      NextPc = 17'(10 * (k + 1));
      step();
    end
    checks++;
    if (StackDepth !== 4'd8 || RetAddr !== 17'd71
        || Fault !== 1'b0) begin
      errors++;
      $display("FAIL fill got d=%0d ra=%0d f=%b want 8 71 0",
               StackDepth, RetAddr, Fault);
    end
    NextPc = 17'd90;
    step();
    checks++;
    if (Fault !== 1'b1 || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags got f=%b iv=%b want 1 0",
               Fault, InstrValid);
    end
    checks++;
    if (StackDepth !== 4'd8 || RetAddr !== 17'd71
        || Pc !== 17'd90) begin
      errors++;
      $display("FAIL ovf_state got d=%0d ra=%0d pc=%0d want 8 71 90",
               StackDepth, RetAddr, Pc);
    end
    Call = 0;
    Ret = 1;
    NextPc = 17'd123;
    step();
    step();
    Ret = 0;
    checks++;
    if (Pc !== 17'd90 || StackDepth !== 4'd8
        || Fault !== 1'b1) begin
      errors++;
      $display("FAIL ovf_frozen got pc=%0d d=%0d f=%b want 90 8 1",
               Pc, StackDepth, Fault);
    end
  endtask

  task automatic test_underflow_reset();
    boot();
    Ret = 1;
    NextPc = 17'h00055;
    step();
    Ret = 0;
    checks++;
    if (Fault !== 1'b1 || Pc !== 17'h00055
        || StackDepth !== 4'd0) begin
      errors++;
      $display("FAIL unf got f=%b pc=%h d=%0d want 1 55 0",
               Fault, Pc, StackDepth);
    end
    #2;
    Reset_n = 0;
    #1;
    checks++;
    if (Fault !== 1'b0 || Pc !== 17'h0
        || InstrValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset got f=%b pc=%h iv=%b want 0 0 0",
               Fault, Pc, InstrValid);
    end
    Reset_n = 1;
  endtask

  task automatic test_replace_empty();
    boot();
    Call = 1;
    Ret = 1;
    NextPc = 17'h00077;
    step();
    Call = 0;
    Ret = 0;
    checks++;
    if (Fault !== 1'b1 || StackDepth !== 4'd0) begin
      errors++;
      $display("FAIL repl_empty got f=%b d=%0d want 1 0",
               Fault, StackDepth);
    end
  endtask

  task automatic test_stall_replace();
    boot();
    Call = 1;
    NextPc = 17'h00040;
    step();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      NextPc = 17'(17'h00300 + k);
      Call = k[0];
      Ret = ~k[0];
      step();
      checks++;
      if (Pc !== 17'h00040 || StackDepth !== 4'd1
          || RetAddr !== 17'h00001) begin
        errors++;
        $display("FAIL stall%0d got pc=%h d=%0d ra=%h want 40 1 1",
                 k, Pc, StackDepth, RetAddr);
      end
    end
    Stall = 0;
    Call = 1;
    Ret = 0;
    NextPc = 17'h00050;
    step();
    checks++;
    if (StackDepth !== 4'd2 || RetAddr !== 17'h00041) begin
      errors++;
      $display("FAIL push2 got d=%0d ra=%h want 2 41",
               StackDepth, RetAddr);
    end
    Ret = 1;
    NextPc = 17'h00060;
    step();
    checks++;
    if (StackDepth !== 4'd2 || RetAddr !== 17'h00051
        || Pc !== 17'h00060) begin
      errors++;
      $display("FAIL replace got d=%0d ra=%h pc=%h want 2 51 60",
               StackDepth, RetAddr, Pc);
    end
    Call = 0;
    step();
    Ret = 0;
    checks++;
    if (StackDepth !== 4'd1 || RetAddr !== 17'h00001
        || Fault !== 1'b0) begin
      errors++;
      $display("FAIL pop_after got d=%0d ra=%h f=%b want 1 1 0",
               StackDepth, RetAddr, Fault);
    end
  endtask
`else
  task automatic test_stall();
    boot();
    NextPc = 17'h00040;
    step();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      NextPc = 17'(17'h00300 + k);
      step();
      checks++;
      if (Pc !== 17'h00040) begin
        errors++;
        $display("FAIL stall%0d got pc=%h want 40", k, Pc);
      end
    end
    Stall = 0;
    NextPc = 17'h00050;
    step();
    checks++;
    if (Pc !== 17'h00050) begin
      errors++;
      $display("FAIL unstall got pc=%h want 50", Pc);
    end
  endtask

  task automatic test_no_ras();
    boot();
    for (int k = 0; k < 12; k++) begin
      Call = (k % 3) != 2;
      Ret = (k % 3) != 0;
      NextPc = 17'(k + 1);
      step();
      checks++;
      if (RetAddr !== 17'h0 || StackDepth !== 4'd0
          || Fault !== 1'b0 || InstrValid !== 1'b1
          || Pc !== 17'(k + 1)) begin
        errors++;
        $display("FAIL noras%0d got ra=%h d=%0d f=%b iv=%b pc=%h",
                 k, RetAddr, StackDepth, Fault, InstrValid, Pc);
      end
    end
    Call = 0;
    Ret = 0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    Reset_n = 1;
    NextPc = '0;
    Stall = 0;
    Call = 0;
    Ret = 0;
    test_reset();
    test_boot();
    test_wrap();
`ifdef PC_SEQ_RAS_EN
    test_call_ret();
    test_overflow();
    test_underflow_reset();
    test_replace_empty();
    test_stall_replace();
`else
    test_stall();
    test_no_ras();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
